// File: rtl/activation_feed_ctrl.sv
// -----------------------------------------------------------------------------
// activation_feed_ctrl
//
// Sequencer for the activation path into the systolic array. In normal mode it
// streams a block of activation vectors out of activation_mem into the skew
// buffer, then zero-flushes the buffer so the diagonal skew fully drains into
// the array. When the BIST engine asks for the array input it is handed over
// (never pre-empting a feed in progress) and the buffer's test_mode select is
// driven.
//
// Ports
//   clk          clock
//   rst_n        asynchronous active-low reset
//   start        one-cycle feed request, honoured only in IDLE
//   base_addr    first activation_mem address, captured with start
//   num_vectors  vector count, captured with start (0 = empty feed)
//   bist_req     BIST requests ownership of the array input (held until granted)
//   bist_done    BIST finished (level or pulse)
//   mem_rd_en    activation_mem read enable
//   mem_rd_addr  activation_mem read address (0 whenever not reading)
//   act_valid    memory data at the buffer input is valid (mem_rd_en delayed 1)
//   zero_in      force the buffer input to zero (flush)
//   test_mode    buffer select: 1 = BIST data path
//   bist_gnt     BIST owns the array
//   busy         feed in progress (FEED, DRAIN, DONE)
//   done         one-cycle pulse at the end of a feed
//
// Every output is a register or a decode of the state register, so there is
// no combinational path from any input to any output.
// -----------------------------------------------------------------------------
module activation_feed_ctrl #(
    parameter int SYSTOLIC_SIZE = 8,
    parameter int ADDR_WIDTH    = 8,
    parameter int LEN_WIDTH     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  num_vectors,
    input  logic                  bist_req,
    input  logic                  bist_done,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    output logic                  act_valid,
    output logic                  zero_in,
    output logic                  test_mode,
    output logic                  bist_gnt,
    output logic                  busy,
    output logic                  done
);

    localparam int DRAIN_W = $clog2(SYSTOLIC_SIZE + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FEED  = 3'd1,
        DRAIN = 3'd2,
        DONE  = 3'd3,
        BIST  = 3'd4
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  cnt;
    logic [DRAIN_W-1:0]    drain_cnt;
    logic                  vld_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                // BIST wins over a simultaneous start; that start is dropped.
                if (bist_req) begin
                    state_nxt = BIST;
                end else if (start) begin
                    state_nxt = (num_vectors != '0) ? FEED : DONE;
                end
            end
            FEED: begin
                if (cnt == LEN_WIDTH'(1)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt == DRAIN_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // A request held during the feed is granted right after done.
                state_nxt = bist_req ? BIST : IDLE;
            end
            BIST: begin
                if (bist_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr      <= '0;
            cnt       <= '0;
            drain_cnt <= '0;
            vld_p1    <= 1'b0;
        end else begin
            // --- stage p1: read data returns one cycle after the request ---
            vld_p1 <= (state == FEED);
            case (state)
                IDLE: begin
                    if (state_nxt == FEED) begin
                        addr <= base_addr;
                        cnt  <= num_vectors;
                    end
                end
                FEED: begin
                    addr <= addr + ADDR_WIDTH'(1);
                    cnt  <= cnt - LEN_WIDTH'(1);
                    // Flush covers one cycle of read latency plus SIZE-1 of skew.
                    if (cnt == LEN_WIDTH'(1)) begin
                        drain_cnt <= DRAIN_W'(SYSTOLIC_SIZE);
                    end
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt - DRAIN_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_rd_en   = (state == FEED);
    assign mem_rd_addr = (state == FEED) ? addr : '0;
    assign act_valid   = vld_p1;
    assign zero_in     = (state == DRAIN);
    assign test_mode   = (state == BIST);
    assign bist_gnt    = (state == BIST);
    assign busy        = (state == FEED) || (state == DRAIN) || (state == DONE);
    assign done        = (state == DONE);

endmodule

// File: tb/tb_activation_feed_ctrl.sv
module tb_activation_feed_ctrl;

    localparam int S = 8;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] base_addr;
    logic [7:0] num_vectors;
    logic       bist_req;
    logic       bist_done;
    logic       mem_rd_en;
    logic [7:0] mem_rd_addr;
    logic       act_valid;
    logic       zero_in;
    logic       test_mode;
    logic       bist_gnt;
    logic       busy;
    logic       done;

    activation_feed_ctrl #(
        .SYSTOLIC_SIZE(S),
        .ADDR_WIDTH(8),
        .LEN_WIDTH(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .base_addr(base_addr),
        .num_vectors(num_vectors),
        .bist_req(bist_req),
        .bist_done(bist_done),
        .mem_rd_en(mem_rd_en),
        .mem_rd_addr(mem_rd_addr),
        .act_valid(act_valid),
        .zero_in(zero_in),
        .test_mode(test_mode),
        .bist_gnt(bist_gnt),
        .busy(busy),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    // Expected events: key = cycle*8 + kind, value = expected address (reads).
    // Kinds: 0 rd_en, 1 act_valid, 2 zero_in, 3 done, 4 busy, 5 bist_gnt, 6 test_mode
    int exp_map[int];

    task automatic expect_evt(input int k, input int c, input int a);
        exp_map[c * 8 + k] = a;
    endtask

    task automatic expect_range(input int k, input int c0, input int c1);
        for (int c = c0; c <= c1; c++) expect_evt(k, c, 0);
    endtask

    task automatic chk_evt(input int k, input logic sig, input string nm);
        int key;
        key = cyc * 8 + k;
        if (sig) begin
            checks++;
            if (!exp_map.exists(key)) begin
                errors++;
                $display("FAIL %s: high at cycle %0d, required low", nm, cyc);
            end else begin
                if (k == 0 && mem_rd_addr != 8'(exp_map[key])) begin
                    errors++;
                    $display("FAIL rd_addr: cycle %0d got 0x%02h, required 0x%02h",
                             cyc, mem_rd_addr, 8'(exp_map[key]));
                end
                exp_map.delete(key);
            end
        end else if (exp_map.exists(key)) begin
            checks++;
            errors++;
            $display("FAIL %s: low at cycle %0d, required high", nm, cyc);
            exp_map.delete(key);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk_evt(0, mem_rd_en, "rd_en");
            chk_evt(1, act_valid, "act_valid");
            chk_evt(2, zero_in,   "zero_in");
            chk_evt(3, done,      "done");
            chk_evt(4, busy,      "busy");
            chk_evt(5, bist_gnt,  "bist_gnt");
            chk_evt(6, test_mode, "test_mode");
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string nm);
        logic [14:0] v;
        v = {mem_rd_en, mem_rd_addr, act_valid, zero_in, test_mode, bist_gnt, busy, done};
        checks++;
        if (v != '0) begin
            errors++;
            $display("FAIL %s: outputs 0x%04h, required 0x0000", nm, v);
        end
    endtask

    // Feed of n vectors from base b. ign_off / bist_off (0 = unused) are
    // offsets from the start edge at which a stray start / a bist_req appear.
    task automatic do_feed(input logic [7:0] b, input logic [7:0] n,
                           input int ign_off, input int bist_off, input int bist_len);
        int t, last, d;
        t = cyc;
        if (n == 0) begin
            last = t + 1;
            expect_evt(3, last, 0);
            expect_evt(4, last, 0);
        end else begin
            last = t + int'(n) + S + 1;
            for (int i = 0; i < int'(n); i++) begin
                expect_evt(0, t + 1 + i, int'(8'(b + 8'(i))));
                expect_evt(1, t + 2 + i, 0);
            end
            expect_range(2, t + int'(n) + 1, t + int'(n) + S);
            expect_evt(3, last, 0);
            expect_range(4, t + 1, last);
        end
        d = last + 1 + bist_len;
        if (bist_off != 0) begin
            expect_range(5, last + 1, d);
            expect_range(6, last + 1, d);
        end
        start = 1'b1;
        base_addr = b;
        num_vectors = n;
        step();
        start = 1'b0;
        base_addr = 8'($urandom_range(0, 255));
        num_vectors = 8'($urandom_range(0, 255));
        while (cyc <= last) begin
            if (ign_off != 0 && cyc == t + ign_off) begin
                start = 1'b1;
                num_vectors = 8'($urandom_range(1, 9));
            end
            if (bist_off != 0 && cyc == t + bist_off) bist_req = 1'b1;
            step();
            start = 1'b0;
        end
        if (bist_off != 0) begin
            while (cyc < d) step();
            bist_done = 1'b1;
            bist_req = 1'b0;
            step();
            bist_done = 1'b0;
        end
    endtask

    task automatic do_bist(input bit with_start, input int len);
        int t, d;
        t = cyc;
        d = t + 1 + len;
        expect_range(5, t + 1, d);
        expect_range(6, t + 1, d);
        bist_req = 1'b1;
        if (with_start) begin
            start = 1'b1;
            base_addr = 8'($urandom_range(0, 255));
            num_vectors = 8'($urandom_range(1, 9));
        end
        step();
        start = 1'b0;
        while (cyc < d) step();
        bist_done = 1'b1;
        bist_req = 1'b0;
        step();
        bist_done = 1'b0;
    endtask

    initial begin
        int n, last_off, ign, bo;
        rst_n = 1'b0;
        start = 1'b0;
        base_addr = '0;
        num_vectors = '0;
        bist_req = 1'b0;
        bist_done = 1'b0;
        repeat (3) step();
        chk_zero("reset_hold");
        rst_n = 1'b1;
        repeat (5) begin
            step();
            chk_zero("idle_after_reset");
        end
        mon_en = 1'b1;

        do_feed(8'h10, 8'd3, 0, 0, 0);
        do_feed(8'hFE, 8'd4, 0, 0, 0);
        do_feed(8'h00, 8'd0, 0, 0, 0);
        do_bist(1'b1, 5);
        do_feed(8'h33, 8'd5, 0, 0, 0);
        do_feed(8'h80, 8'd2, 5, 2, 3);
        do_feed(8'hC0, 8'd0, 0, 1, 2);

        // Asynchronous reset in the middle of a feed.
        mon_en = 1'b0;
        start = 1'b1;
        base_addr = 8'h40;
        num_vectors = 8'd6;
        step();
        start = 1'b0;
        repeat (2) step();
        checks++;
        if (mem_rd_en !== 1'b1 || mem_rd_addr !== 8'h42) begin
            errors++;
            $display("FAIL mid_feed: rd_en %b addr 0x%02h, required 1 / 0x42", mem_rd_en, mem_rd_addr);
        end
        #3 rst_n = 1'b0;
        #1 chk_zero("async_reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        chk_zero("after_reset_release");
        mon_en = 1'b1;

        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 9) < 7) begin
                n = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 12));
                last_off = (n == 0) ? 1 : n + S + 1;
                ign = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, last_off)) : 0;
                bo  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, last_off)) : 0;
                do_feed(8'($urandom_range(0, 255)), 8'(n), ign, bo, int'($urandom_range(0, 4)));
            end else begin
                do_bist(1'($urandom_range(0, 1)), int'($urandom_range(0, 6)));
            end
            repeat ($urandom_range(0, 3)) step();
        end

        repeat (4) step();
        checks++;
        if (exp_map.size() != 0) begin
            errors++;
            $display("FAIL leftover_events: %0d expected events never seen, required 0", exp_map.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
